// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the EX stage and mult_div_unit.
//   start, op, a, b     : request (driven by the master, sampled by the unit in IDLE)
//   busy, done          : handshake status from the unit
//   hi, lo, div_by_zero : result registers (remainder/quotient or product halves)
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULTU/MULT/DIVU/DIV unit.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mult_div_if.slave (start/op/a/b in; busy/done/hi/lo/div_by_zero out)
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. A request accepted in IDLE spends
// WIDTH cycles in CALC (one bit per cycle on operand magnitudes) and one cycle
// in FIX, where the sign correction is applied and HI/LO are written.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    mult_div_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_main;   // negate product / quotient in FIX
    logic             r_neg_rem;    // remainder takes the dividend's sign
    logic             r_b_zero;
    logic [WIDTH-1:0] r_a;          // A as latched, returned in HI on divide by zero
    logic [WIDTH-1:0] r_opnd;       // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] r_acc_hi;     // partial product upper half / partial remainder
    logic [WIDTH-1:0] r_acc_lo;     // multiplier bits shifting out / dividend -> quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    // Operand magnitudes; 0x80..0 negates to itself, which is the correct
    // unsigned magnitude.
    logic             w_signed;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    assign w_signed = bus.op[0];
    assign w_mag_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_mag_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add step: add the multiplicand when the low multiplier bit is set,
    // then shift the whole 2*WIDTH accumulator right (carry enters at the top).
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

    // Restoring step: bring in the next dividend bit and trial-subtract.
    // Bit WIDTH of the difference is set exactly when the subtraction borrows.
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_diff;
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_main ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_main ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_neg_rem  ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_a        <= '0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_is_div   <= bus.op[1];
                        r_neg_main <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_rem  <= w_signed & bus.a[WIDTH-1];
                        r_b_zero   <= (bus.b == '0);
                        r_a        <= bus.a;
                        r_opnd     <= bus.op[1] ? w_mag_b : w_mag_a;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= bus.op[1] ? w_mag_a : w_mag_b;
                        r_cnt      <= '0;
                        r_dz       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        if (!w_div_diff[WIDTH]) begin
                            r_acc_hi <= w_div_diff[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= w_div_shift[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_is_div) begin
                        if (r_b_zero) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                            r_dz <= 1'b1;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dz;
endmodule
